// File: rtl/axi_pkg.sv
// Shared types and response codes for the AXI slave memory model.
package axi_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_RESP
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } rstate_e;

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational beat-address advance and burst legality for one AXI channel.
module axi_addr_gen
  import axi_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr,
  output logic        burst_err
);

  burst_e      btype;
  logic [31:0] step;
  logic [31:0] wrap_mask;
  logic [31:0] incr_addr;

  always_comb begin
    btype     = burst_e'(burst);
    step      = 32'd1 << size;
    wrap_mask = ((32'(len) + 32'd1) << size) - 32'd1;
    incr_addr = addr + step;
    case (btype)
      FIXED:   next_addr = addr;
      // Upper bits pin the aligned window, low bits roll over inside it
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = incr_addr;
    endcase
    burst_err = (size > 3'd2) || (btype == RSVD) ||
                ((btype == WRAP) &&
                 !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  end

endmodule

// File: rtl/axi_slave_mem.sv
// AXI4 slave memory: independent write and read FSMs over a shared word array.
module axi_slave_mem
  import axi_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        aw_valid,
  output logic        aw_ready,
  input  logic [31:0] aw_addr,
  input  logic [7:0]  aw_len,
  input  logic [2:0]  aw_size,
  input  logic [1:0]  aw_burst,
  input  logic        w_valid,
  output logic        w_ready,
  input  logic [31:0] w_data,
  input  logic [3:0]  w_strb,
  input  logic        w_last,
  output logic        b_valid,
  input  logic        b_ready,
  output logic [1:0]  b_resp,
  input  logic        ar_valid,
  output logic        ar_ready,
  input  logic [31:0] ar_addr,
  input  logic [7:0]  ar_len,
  input  logic [2:0]  ar_size,
  input  logic [1:0]  ar_burst,
  output logic        r_valid,
  input  logic        r_ready,
  output logic [31:0] r_data,
  output logic        r_last,
  output logic [1:0]  r_resp
);

  localparam int unsigned IDX_W = $clog2(MEM_DEPTH);

  function automatic logic in_range(input logic [31:0] a);
    return (a >> (IDX_W + 2)) == 32'd0;
  endfunction

  logic [31:0] mem_q [MEM_DEPTH];

  // write channel state
  wstate_e     wstate_q, wstate_d;
  logic [31:0] waddr_q, waddr_d;
  logic [7:0]  wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0]  wsize_q, wsize_d;
  logic [1:0]  wburst_q, wburst_d;
  logic        werr_q, werr_d;
  logic        aw_ready_q, aw_ready_d, w_ready_q, w_ready_d, b_valid_q, b_valid_d;
  logic [1:0]  b_resp_q, b_resp_d;
  logic        mem_we, w_beat_err, w_burst_err;
  logic [31:0] w_next;

  // read channel state
  rstate_e     rstate_q, rstate_d;
  logic [31:0] raddr_q, raddr_d;
  logic [7:0]  rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [2:0]  rsize_q, rsize_d;
  logic [1:0]  rburst_q, rburst_d;
  logic        rbad_q, rbad_d;
  logic        ar_ready_q, ar_ready_d, r_valid_q, r_valid_d, r_last_q, r_last_d;
  logic [31:0] r_data_q, r_data_d;
  logic [1:0]  r_resp_q, r_resp_d;
  logic        r_beat_err, r_burst_err;
  logic [31:0] r_next, rg_addr;
  logic [7:0]  rg_len;
  logic [2:0]  rg_size;
  logic [1:0]  rg_burst;

  axi_addr_gen u_wgen (
    .addr      (waddr_q),
    .len       (wlen_q),
    .size      (wsize_q),
    .burst     (wburst_q),
    .next_addr (w_next),
    .burst_err (w_burst_err)
  );

  // Idle: judge the incoming AR request; busy: advance the latched burst
  always_comb begin
    rg_addr  = (rstate_q == R_IDLE) ? ar_addr  : raddr_q;
    rg_len   = (rstate_q == R_IDLE) ? ar_len   : rlen_q;
    rg_size  = (rstate_q == R_IDLE) ? ar_size  : rsize_q;
    rg_burst = (rstate_q == R_IDLE) ? ar_burst : rburst_q;
  end

  axi_addr_gen u_rgen (
    .addr      (rg_addr),
    .len       (rg_len),
    .size      (rg_size),
    .burst     (rg_burst),
    .next_addr (r_next),
    .burst_err (r_burst_err)
  );

  always_comb begin
    wstate_d   = wstate_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    wbeat_d    = wbeat_q;
    werr_d     = werr_q;
    b_resp_d   = b_resp_q;
    mem_we     = 1'b0;
    w_beat_err = 1'b0;
    case (wstate_q)
      W_IDLE: if (aw_ready_q && aw_valid) begin
        waddr_d  = aw_addr;
        wlen_d   = aw_len;
        wsize_d  = aw_size;
        wburst_d = aw_burst;
        wbeat_d  = '0;
        werr_d   = 1'b0;
        wstate_d = W_DATA;
      end
      W_DATA: if (w_ready_q && w_valid) begin
        w_beat_err = w_burst_err || !in_range(waddr_q) || (w_last != (wbeat_q == wlen_q));
        mem_we     = !w_beat_err;
        waddr_d    = w_next;
        wbeat_d    = wbeat_q + 8'd1;
        werr_d     = werr_q || w_beat_err;
        if (wbeat_q == wlen_q) begin
          wstate_d = W_RESP;
          b_resp_d = (werr_q || w_beat_err) ? RESP_SLVERR : RESP_OKAY;
        end
      end
      W_RESP: if (b_valid_q && b_ready) wstate_d = W_IDLE;
      default: wstate_d = W_IDLE;
    endcase
    aw_ready_d = (wstate_d == W_IDLE);
    w_ready_d  = (wstate_d == W_DATA);
    b_valid_d  = (wstate_d == W_RESP);
  end

  always_comb begin
    rstate_d   = rstate_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rsize_d    = rsize_q;
    rburst_d   = rburst_q;
    rbeat_d    = rbeat_q;
    rbad_d     = rbad_q;
    r_data_d   = r_data_q;
    r_last_d   = r_last_q;
    r_resp_d   = r_resp_q;
    r_beat_err = 1'b0;
    case (rstate_q)
      R_IDLE: if (ar_ready_q && ar_valid) begin
        raddr_d    = ar_addr;
        rlen_d     = ar_len;
        rsize_d    = ar_size;
        rburst_d   = ar_burst;
        rbeat_d    = '0;
        rbad_d     = r_burst_err;
        r_beat_err = r_burst_err || !in_range(ar_addr);
        r_data_d   = r_beat_err ? '0 : mem_q[ar_addr[IDX_W+1:2]];
        r_last_d   = (ar_len == 8'd0);
        r_resp_d   = r_beat_err ? RESP_SLVERR : RESP_OKAY;
        rstate_d   = R_DATA;
      end
      R_DATA: if (r_valid_q && r_ready) begin
        if (r_last_q) begin
          rstate_d = R_IDLE;
        end else begin
          raddr_d    = r_next;
          rbeat_d    = rbeat_q + 8'd1;
          r_beat_err = rbad_q || !in_range(r_next);
          r_data_d   = r_beat_err ? '0 : mem_q[r_next[IDX_W+1:2]];
          r_last_d   = ((rbeat_q + 8'd1) == rlen_q);
          r_resp_d   = r_beat_err ? RESP_SLVERR : RESP_OKAY;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
    ar_ready_d = (rstate_d == R_IDLE);
    r_valid_d  = (rstate_d == R_DATA);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wstate_q   <= W_IDLE;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wsize_q    <= '0;
      wburst_q   <= '0;
      wbeat_q    <= '0;
      werr_q     <= 1'b0;
      aw_ready_q <= 1'b0;
      w_ready_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      b_resp_q   <= RESP_OKAY;
      rstate_q   <= R_IDLE;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rsize_q    <= '0;
      rburst_q   <= '0;
      rbeat_q    <= '0;
      rbad_q     <= 1'b0;
      ar_ready_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_last_q   <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RESP_OKAY;
    end else begin
      wstate_q   <= wstate_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wsize_q    <= wsize_d;
      wburst_q   <= wburst_d;
      wbeat_q    <= wbeat_d;
      werr_q     <= werr_d;
      aw_ready_q <= aw_ready_d;
      w_ready_q  <= w_ready_d;
      b_valid_q  <= b_valid_d;
      b_resp_q   <= b_resp_d;
      rstate_q   <= rstate_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rsize_q    <= rsize_d;
      rburst_q   <= rburst_d;
      rbeat_q    <= rbeat_d;
      rbad_q     <= rbad_d;
      ar_ready_q <= ar_ready_d;
      r_valid_q  <= r_valid_d;
      r_last_q   <= r_last_d;
      r_data_q   <= r_data_d;
      r_resp_q   <= r_resp_d;
    end
  end

  // Storage survives reset, so it has no reset branch
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (w_strb[b]) mem_q[waddr_q[IDX_W+1:2]][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

  assign aw_ready = aw_ready_q;
  assign w_ready  = w_ready_q;
  assign b_valid  = b_valid_q;
  assign b_resp   = b_resp_q;
  assign ar_ready = ar_ready_q;
  assign r_valid  = r_valid_q;
  assign r_data   = r_data_q;
  assign r_last   = r_last_q;
  assign r_resp   = r_resp_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Self-checking bench for axi_slave_mem: vector table, reference memory model, R/B scoreboards.
module tb_axi_slave_mem;

  logic        clk = 1'b0;
  logic        reset;
  logic        aw_valid, aw_ready, w_valid, w_ready, w_last, b_valid, b_ready;
  logic [31:0] aw_addr, w_data, ar_addr, r_data;
  logic [7:0]  aw_len, ar_len;
  logic [2:0]  aw_size, ar_size;
  logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
  logic [3:0]  w_strb;
  logic        ar_valid, ar_ready, r_valid, r_ready, r_last;

  axi_slave_mem #(.MEM_DEPTH(1024)) dut (
    .clk(clk), .reset(reset),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr), .aw_len(aw_len),
    .aw_size(aw_size), .aw_burst(aw_burst),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
    .b_valid(b_valid), .b_ready(b_ready), .b_resp(b_resp),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .ar_size(ar_size), .ar_burst(ar_burst),
    .r_valid(r_valid), .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .r_resp(r_resp)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic [1:0]  r;
  } rexp_t;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [31:0] data;
    logic [3:0]  strb;
    bit          bad_last;
    logic [1:0]  bresp;
  } vec_t;

  rexp_t       exp_r[$];
  logic [1:0]  exp_b[$];
  logic [31:0] model_mem [1024];
  int          pass_cnt = 0;
  int          total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    else pass_cnt++;
  endtask

  function automatic logic [31:0] tb_next(input logic [31:0] a, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] bytes, base;
    if (burst == 2'b00) return a;
    if (burst == 2'b10) begin
      bytes = (32'(len) + 1) * (32'd1 << size);
      base  = a - (a % bytes);
      return base + ((a - base + (32'd1 << size)) % bytes);
    end
    return a + (32'd1 << size);
  endfunction

  function automatic bit tb_legal(input logic [7:0] len, input logic [2:0] size,
                                  input logic [1:0] burst);
    if (size > 3'd2 || burst == 2'b11) return 1'b0;
    if (burst == 2'b10 && !(len inside {8'd1, 8'd3, 8'd7, 8'd15})) return 1'b0;
    return 1'b1;
  endfunction

  always @(negedge clk) begin
    rexp_t e;
    if (!reset && r_valid && r_ready) begin
      if (exp_r.size() == 0) chk("r_unexpected_beat", 32'd1, 32'd0);
      else begin
        e = exp_r.pop_front();
        chk("r_data", r_data, e.d);
        chk("r_last", 32'(r_last), 32'(e.l));
        chk("r_resp", 32'(r_resp), 32'(e.r));
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && b_valid && b_ready) begin
      if (exp_b.size() == 0) chk("b_unexpected", 32'd1, 32'd0);
      else chk("b_resp", 32'(b_resp), 32'(exp_b.pop_front()));
    end
  end

  task automatic push_read(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] a;
    bit err;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      err = !tb_legal(len, size, burst) || (a >= 32'd4096);
      exp_r.push_back('{err ? 32'd0 : model_mem[a[11:2]], (i == int'(len)), err ? 2'b10 : 2'b00});
      a = tb_next(a, len, size, burst);
    end
  endtask

  task automatic drive_aw(input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst);
    int t;
    aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_size = size; aw_burst = burst;
    t = 0;
    @(negedge clk);
    while (!aw_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("aw_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    aw_valid = 1'b0;
    chk("aw_to_w_ready", 32'({aw_ready, w_ready}), 32'b01);
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [31:0] base, input logic [3:0] strb,
                          input bit bad_last, input logic [1:0] bresp);
    logic [31:0] a;
    bit lst, err;
    int t;
    exp_b.push_back(bresp);
    drive_aw(addr, len, size, burst);
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      lst = (i == int'(len)) ^ bad_last;
      w_valid = 1'b1; w_data = base + 32'(i); w_strb = strb; w_last = lst;
      err = !tb_legal(len, size, burst) || (a >= 32'd4096) || (lst != (i == int'(len)));
      if (!err)
        for (int b = 0; b < 4; b++)
          if (strb[b]) model_mem[a[11:2]][8*b +: 8] = w_data[8*b +: 8];
      a = tb_next(a, len, size, burst);
      t = 0;
      @(negedge clk);
      while (!w_ready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) chk("w_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
    end
    w_valid = 1'b0; w_last = 1'b0;
    chk("last_w_to_b_valid", 32'({b_valid, w_ready}), 32'b10);
    @(posedge clk); #1;
    chk("b_to_aw_ready", 32'(aw_ready), 32'd1);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    int t;
    push_read(addr, len, size, burst);
    ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_size = size; ar_burst = burst;
    t = 0;
    @(negedge clk);
    while (!ar_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) chk("ar_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    chk("ar_to_r_valid", 32'({ar_ready, r_valid}), 32'b01);
    t = 0;
    @(negedge clk);
    while (!(r_valid && r_ready && r_last) && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) chk("r_last_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    chk("r_done_ar_ready", 32'({r_valid, ar_ready}), 32'b01);
  endtask

  vec_t vecs [23];

  initial begin
    vecs[0]  = '{1, 32'h10,   8'd3, 3'd2, 2'b01, 32'h1,        4'hF, 0, 2'b00};
    vecs[1]  = '{0, 32'h10,   8'd3, 3'd2, 2'b01, 32'h0,        4'h0, 0, 2'b00};
    vecs[2]  = '{1, 32'h30,   8'd3, 3'd2, 2'b01, 32'h100,      4'hF, 0, 2'b00};
    vecs[3]  = '{0, 32'h38,   8'd3, 3'd2, 2'b10, 32'h0,        4'h0, 0, 2'b00};
    vecs[4]  = '{1, 32'h80,   8'd0, 3'd2, 2'b01, 32'h0,        4'hF, 0, 2'b00};
    vecs[5]  = '{1, 32'h80,   8'd0, 3'd2, 2'b01, 32'hAABBCCDD, 4'h5, 0, 2'b00};
    vecs[6]  = '{0, 32'h80,   8'd0, 3'd2, 2'b01, 32'h0,        4'h0, 0, 2'b00};
    vecs[7]  = '{1, 32'h0,    8'd0, 3'd2, 2'b01, 32'h5555,     4'hF, 0, 2'b00};
    vecs[8]  = '{1, 32'h1000, 8'd0, 3'd2, 2'b01, 32'hDEAD,     4'hF, 0, 2'b10};
    vecs[9]  = '{0, 32'h1000, 8'd0, 3'd2, 2'b01, 32'h0,        4'h0, 0, 2'b00};
    vecs[10] = '{0, 32'h0,    8'd0, 3'd2, 2'b01, 32'h0,        4'h0, 0, 2'b00};
    vecs[11] = '{1, 32'h40,   8'd2, 3'd2, 2'b00, 32'h7,        4'hF, 0, 2'b00};
    vecs[12] = '{0, 32'h40,   8'd1, 3'd2, 2'b00, 32'h0,        4'h0, 0, 2'b00};
    vecs[13] = '{1, 32'h50,   8'd1, 3'd2, 2'b01, 32'h50,       4'hF, 0, 2'b00};
    vecs[14] = '{1, 32'h50,   8'd0, 3'd3, 2'b01, 32'h77,       4'hF, 0, 2'b10};
    vecs[15] = '{1, 32'h50,   8'd1, 3'd2, 2'b11, 32'h88,       4'hF, 0, 2'b10};
    vecs[16] = '{1, 32'h50,   8'd1, 3'd2, 2'b01, 32'h99,       4'hF, 1, 2'b10};
    vecs[17] = '{0, 32'h50,   8'd1, 3'd2, 2'b01, 32'h0,        4'h0, 0, 2'b00};
    vecs[18] = '{0, 32'h30,   8'd2, 3'd2, 2'b10, 32'h0,        4'h0, 0, 2'b00};
    vecs[19] = '{0, 32'h50,   8'd1, 3'd2, 2'b11, 32'h0,        4'h0, 0, 2'b00};
    vecs[20] = '{1, 32'hFF8,  8'd3, 3'd2, 2'b01, 32'hF0,       4'hF, 0, 2'b10};
    vecs[21] = '{0, 32'hFF8,  8'd3, 3'd2, 2'b01, 32'h0,        4'h0, 0, 2'b00};
    vecs[22] = '{1, 32'h200,  8'd3, 3'd2, 2'b01, 32'hC0,       4'hF, 0, 2'b00};

    for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;
    reset = 1'b1;
    aw_valid = 0; aw_addr = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
    w_valid = 0; w_data = 0; w_strb = 0; w_last = 0; b_ready = 1'b1;
    ar_valid = 0; ar_addr = 0; ar_len = 0; ar_size = 0; ar_burst = 0; r_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_handshakes", 32'({aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last}), 32'd0);
    chk("reset_resps", 32'({b_resp, r_resp}), 32'd0);
    chk("reset_r_data", r_data, 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_reset_ready", 32'({aw_ready, ar_ready}), 32'b11);

    for (int i = 0; i < 23; i++) begin
      if (vecs[i].wr)
        do_write(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst,
                 vecs[i].data, vecs[i].strb, vecs[i].bad_last, vecs[i].bresp);
      else
        do_read(vecs[i].addr, vecs[i].len, vecs[i].size, vecs[i].burst);
    end

    // Reset during beat 2 of a 4-beat write to 0x200 (old contents 0xC0..0xC3)
    drive_aw(32'h200, 8'd3, 3'd2, 2'b01);
    w_valid = 1'b1; w_strb = 4'hF; w_last = 1'b0; w_data = 32'hD0;
    @(posedge clk); #1;
    w_data = 32'hD1;
    @(posedge clk); #1;
    w_data = 32'hD2;
    #2;
    reset = 1'b1;
    #1;
    chk("midburst_reset_outs", 32'({aw_ready, w_ready, b_valid, ar_ready, r_valid, r_last}), 32'd0);
    chk("midburst_reset_resp", 32'({b_resp, r_resp}), 32'd0);
    w_valid = 1'b0;
    model_mem[32'h200 >> 2] = 32'hD0;
    model_mem[32'h204 >> 2] = 32'hD1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("midburst_aw_ready", 32'(aw_ready), 32'd1);
    do_read(32'h200, 8'd3, 3'd2, 2'b01);

    // Backpressure on beat 1 of an INCR read of 1,2,3,4
    push_read(32'h10, 8'd3, 3'd2, 2'b01);
    ar_valid = 1'b1; ar_addr = 32'h10; ar_len = 8'd3; ar_size = 3'd2; ar_burst = 2'b01;
    @(negedge clk);
    chk("bp_ar_ready", 32'(ar_ready), 32'd1);
    @(posedge clk); #1;
    ar_valid = 1'b0;
    @(posedge clk); #1;
    r_ready = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_data", r_data, 32'd2);
      chk("bp_hold_last", 32'({r_valid, r_last}), 32'b10);
    end
    @(posedge clk); #1;
    r_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_next_beat", r_data, 32'd3);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_done", 32'({r_valid, ar_ready}), 32'b01);

    chk("r_scoreboard_empty", 32'(exp_r.size()), 32'd0);
    chk("b_scoreboard_empty", 32'(exp_b.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
